// File: rtl/alu_ex_stage_pkg.sv
// alu_ex_stage_pkg: shared processor constants and ALU op-code encodings.
// Contents: DATA_WIDTH/ADDR_WIDTH defaults and ALUOpT (ADD 0x01 .. PASSB 0x0B).
package alu_ex_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    typedef enum logic [7:0] {
        OP_ADD   = 8'h01,
        OP_SUB   = 8'h02,
        OP_XOR   = 8'h03,
        OP_OR    = 8'h04,
        OP_AND   = 8'h05,
        OP_SLL   = 8'h06,
        OP_SRL   = 8'h07,
        OP_SRA   = 8'h08,
        OP_SLT   = 8'h09,
        OP_SLTU  = 8'h0A,
        OP_PASSB = 8'h0B
    } ALUOpT;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU, result and illegal-op flag from op, a, b.
// Ports: i_op (ALUOpT code), i_a/i_b operands -> o_result, o_illegal.
module alu_core
    import alu_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [7:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_illegal
);

    localparam int SW = $clog2(DATA_WIDTH);

    logic [SW-1:0] w_shamt;

    assign w_shamt = i_b[SW-1:0];

    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        case (i_op)
            OP_ADD:   o_result = i_a + i_b;
            OP_SUB:   o_result = i_a - i_b;
            OP_XOR:   o_result = i_a ^ i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_AND:   o_result = i_a & i_b;
            OP_SLL:   o_result = i_a << w_shamt;
            OP_SRL:   o_result = i_a >> w_shamt;
            OP_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
            OP_SLT:   o_result = {{(DATA_WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            OP_SLTU:  o_result = {{(DATA_WIDTH-1){1'b0}}, i_a < i_b};
            OP_PASSB: o_result = i_b;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ex_stage.sv
// alu_ex_stage: registered ALU execute stage with a main + skid output buffer.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_op/in_a/in_b/in_tag
// upstream request; out_valid/out_ready/out_result/out_zero/out_tag/out_illegal result.
module alu_ex_stage
    import alu_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_illegal
);

    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_illegal;
    logic                  w_zero;
    logic                  w_acc;
    logic                  w_deq;
    logic                  w_s_next;

    logic                  r_in_ready;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_zero;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic                  r_illegal;
    logic                  r_s_valid;
    logic [DATA_WIDTH-1:0] r_s_result;
    logic                  r_s_zero;
    logic [TAG_WIDTH-1:0]  r_s_tag;
    logic                  r_s_illegal;

    alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .i_op      (in_op),
        .i_a       (in_a),
        .i_b       (in_b),
        .o_result  (w_result),
        .o_illegal (w_illegal)
    );

    assign w_zero = ~|w_result;
    assign w_acc  = in_valid & r_in_ready;
    assign w_deq  = r_valid & out_ready;
    // Skid is occupied next cycle if it stays unread, or a new entry lands
    // behind a stalled main register. in_ready is just its registered inverse,
    // so out_ready never reaches in_ready combinationally.
    assign w_s_next = (r_s_valid | (w_acc & r_valid)) & ~w_deq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_tag       <= '0;
            r_illegal   <= 1'b0;
            r_s_valid   <= 1'b0;
            r_s_result  <= '0;
            r_s_zero    <= 1'b1;
            r_s_tag     <= '0;
            r_s_illegal <= 1'b0;
        end else begin
            r_in_ready <= ~w_s_next;
            r_s_valid  <= w_s_next;
            if (w_deq) begin
                // Skid entry is older than anything arriving now (in_ready is low while it is full).
                if (r_s_valid) begin
                    r_result  <= r_s_result;
                    r_zero    <= r_s_zero;
                    r_tag     <= r_s_tag;
                    r_illegal <= r_s_illegal;
                end else if (w_acc) begin
                    r_result  <= w_result;
                    r_zero    <= w_zero;
                    r_tag     <= in_tag;
                    r_illegal <= w_illegal;
                end
                r_valid <= r_s_valid | w_acc;
            end else if (w_acc & ~r_valid) begin
                r_result  <= w_result;
                r_zero    <= w_zero;
                r_tag     <= in_tag;
                r_illegal <= w_illegal;
                r_valid   <= 1'b1;
            end
            if (w_acc & r_valid & ~w_deq) begin
                r_s_result  <= w_result;
                r_s_zero    <= w_zero;
                r_s_tag     <= in_tag;
                r_s_illegal <= w_illegal;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_valid;
    assign out_result  = r_result;
    assign out_zero    = r_zero;
    assign out_tag     = r_tag;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_ex_stage.sv
// tb_alu_ex_stage: randomized and directed check of alu_ex_stage against a queue model.
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic [4:0]  tag;
    } ent_t;

    ent_t       q[$];
    logic [4:0] dep[$];
    logic       m_rdy = 1'b0;
    logic       m_rst = 1'b0;
    logic       started = 1'b0;

    alu_ex_stage #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t ref_alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        ent_t e;
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        int sh = int'(b % 32);
        e.ill = 1'b0;
        e.tag = tag;
        case (op)
            8'h01: e.res = 32'(64'(a) + 64'(b));
            8'h02: e.res = 32'(64'(a) - 64'(b));
            8'h03: e.res = a ^ b;
            8'h04: e.res = a | b;
            8'h05: e.res = a & b;
            8'h06: e.res = 32'(64'(a) * (64'd1 << sh));
            8'h07: e.res = 32'(64'(a) / (64'd1 << sh));
            8'h08: e.res = 32'(sa >>> sh);
            8'h09: e.res = (sa < sb) ? 32'd1 : 32'd0;
            8'h0A: e.res = (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            8'h0B: e.res = b;
            default: begin e.res = 32'd0; e.ill = 1'b1; end
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            q.delete();
            m_rdy = 1'b0;
            m_rst = 1'b1;
        end else begin
            logic acc;
            logic deq;
            acc = in_valid && m_rdy;
            deq = (q.size() > 0) && out_ready;
            if (deq) void'(q.pop_front());
            if (acc) q.push_back(ref_alu(in_op, in_a, in_b, in_tag));
            m_rdy = q.size() < 2;
            m_rst = 1'b0;
        end
    end

    logic        p_hold = 1'b0;
    logic [31:0] p_res;
    logic        p_z;
    logic        p_ill;
    logic [4:0]  p_tag;

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, m_rdy);
            chk("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("out_result", out_result, q[0].res);
                chk("out_zero", out_zero, q[0].z);
                chk("out_illegal", out_illegal, q[0].ill);
                chk("out_tag", out_tag, q[0].tag);
            end
            if (m_rst) begin
                chk("rst_result", out_result, 0);
                chk("rst_zero", out_zero, 1);
                chk("rst_tag", out_tag, 0);
                chk("rst_illegal", out_illegal, 0);
            end
            if (p_hold && !m_rst) begin
                chk("stall_stable_result", out_result, p_res);
                chk("stall_stable_zero", out_zero, p_z);
                chk("stall_stable_tag", out_tag, p_tag);
                chk("stall_stable_illegal", out_illegal, p_ill);
            end
            p_hold = out_valid && !out_ready && !rst;
            p_res  = out_result;
            p_z    = out_zero;
            p_tag  = out_tag;
            p_ill  = out_illegal;
            if (!rst && out_valid && out_ready) dep.push_back(out_tag);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        logic done = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = tag;
        for (int k = 0; k < 100 && !done; k++) begin
            done = in_ready;
            tick();
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_valid; k++) tick();
        chk("drain_empty", out_valid, 0);
    endtask

    task automatic check_main(input string name, input logic [31:0] res, input logic z, input logic ill);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_result"}, out_result, res);
        chk({name, "_zero"}, out_zero, z);
        chk({name, "_illegal"}, out_illegal, ill);
    endtask

    initial begin
        ent_t e;
        int acc_n;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_op = 8'h00;
        in_a = 32'd0;
        in_b = 32'd0;
        in_tag = 5'd0;

        e = ref_alu(8'h01, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("model_add_wrap", {e.res, 31'd0, e.z}, {32'd0, 31'd0, 1'b1});
        e = ref_alu(8'h08, 32'h8000_0000, 32'h24, 5'd0);
        chk("model_sra", e.res, 32'hF800_0000);
        e = ref_alu(8'h07, 32'h8000_0000, 32'h24, 5'd0);
        chk("model_srl", e.res, 32'h0800_0000);
        e = ref_alu(8'h09, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("model_slt", e.res, 32'd1);
        e = ref_alu(8'h0A, 32'hFFFF_FFFF, 32'd1, 5'd0);
        chk("model_sltu", e.res, 32'd0);
        e = ref_alu(8'h0C, 32'h1234, 32'h5678, 5'd0);
        chk("model_illegal", {e.res, 30'd0, e.z, e.ill}, {32'd0, 30'd0, 2'b11});

        repeat (3) tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_zero", out_zero, 1);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", in_ready, 1);

        out_ready = 1'b1;
        send(8'h01, 32'hFFFF_FFFF, 32'd1, 5'd7);
        check_main("add_wrap", 32'd0, 1'b1, 1'b0);
        chk("add_wrap_tag", out_tag, 7);
        send(8'h08, 32'h8000_0000, 32'h24, 5'd1);
        check_main("sra", 32'hF800_0000, 1'b0, 1'b0);
        send(8'h07, 32'h8000_0000, 32'h24, 5'd2);
        check_main("srl", 32'h0800_0000, 1'b0, 1'b0);
        send(8'h09, 32'hFFFF_FFFF, 32'd1, 5'd3);
        check_main("slt", 32'd1, 1'b0, 1'b0);
        send(8'h0A, 32'hFFFF_FFFF, 32'd1, 5'd4);
        check_main("sltu", 32'd0, 1'b1, 1'b0);
        send(8'h00, 32'h55, 32'h66, 5'd5);
        check_main("illegal_00", 32'd0, 1'b1, 1'b1);
        send(8'h0C, 32'h55, 32'h66, 5'd6);
        check_main("illegal_0c", 32'd0, 1'b1, 1'b1);
        tick();

        out_ready = 1'b0;
        dep.delete();
        send(8'h01, 32'd10, 32'd1, 5'd1);
        send(8'h02, 32'd10, 32'd1, 5'd2);
        chk("skid_full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        send(8'h03, 32'd10, 32'd1, 5'd3);
        drain();
        chk("order_count", dep.size(), 3);
        if (dep.size() == 3) begin
            chk("order_tag0", dep[0], 1);
            chk("order_tag1", dep[1], 2);
            chk("order_tag2", dep[2], 3);
        end

        out_ready = 1'b0;
        send(8'h04, 32'd1, 32'd2, 5'd4);
        send(8'h05, 32'd3, 32'd2, 5'd5);
        chk("full_before_reset", in_ready, 0);
        dep.delete();
        rst = 1'b1;
        tick();
        chk("mid_reset_out_valid", out_valid, 0);
        chk("mid_reset_in_ready", in_ready, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        repeat (3) tick();
        chk("no_stale_emit", dep.size(), 0);

        acc_n = 0;
        for (int cyc = 0; cyc < 3000 && acc_n < 100; cyc++) begin
            logic w;
            in_valid = $urandom_range(0, 9) < 7;
            in_op = 8'($urandom_range(0, 12));
            case ($urandom_range(0, 3))
                0: in_a = 32'hFFFF_FFFF;
                1: in_a = 32'h8000_0000;
                default: in_a = $urandom;
            endcase
            in_b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            in_tag = 5'($urandom);
            out_ready = $urandom_range(0, 9) < 6;
            w = in_valid && in_ready;
            tick();
            if (w) acc_n++;
        end
        in_valid = 1'b0;
        chk("random_accepts", acc_n, 100);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ex_stage.md
ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, width of the pass-through destination tag (rd index).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  stage can accept a request.
REQ-007 in_op  input  8  operation code, type ALUOpT.
REQ-008 in_a, in_b  input  DATA_WIDTH each  operands A and B.
REQ-009 in_tag  input  TAG_WIDTH  destination tag, carried unchanged.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_result  output  DATA_WIDTH  ALU result.
REQ-013 out_zero  output  1  high when out_result is all zeros.
REQ-014 out_tag  output  TAG_WIDTH  tag of the result.
REQ-015 out_illegal  output  1  high when the op code was not a defined ALUOpT value.

Function
REQ-016 A transfer SHALL occur on an edge where valid and ready are both high; upstream and downstream sides are independent.
REQ-017 Result SHALL be computed combinationally from in_* and registered; out_valid SHALL rise the cycle after the accepting edge (latency 1).
REQ-018 Storage SHALL be 2 entries: a main output register plus one skid register; full throughput of 1 op/cycle with out_ready held high.
REQ-019 in_ready SHALL be a register output, low exactly when the skid register holds an entry; no combinational path from out_ready to in_ready.
REQ-020 When out_ready is low and the main register is full, an accepted request SHALL go to the skid register; on the next downstream transfer the skid entry moves to the main register in the same edge.
REQ-021 Simultaneous input accept and output transfer with skid empty SHALL load the new result directly into the main register.
REQ-022 Results SHALL leave in acceptance order; no entry dropped or duplicated.
REQ-023 out_* SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 Ops: ADD a+b, SUB a-b (both modulo 2^DATA_WIDTH), XOR, OR, AND bitwise, PASSB = b.
REQ-025 SLL/SRL/SRA SHALL use shift amount b[log2(DATA_WIDTH)-1:0]; SRA sign-fills from a[MSB].
REQ-026 SLT SHALL give 1 if a<b signed, SLTU 1 if a<b unsigned, zero-extended to DATA_WIDTH.
REQ-027 Op codes outside 0x01..0x0B SHALL produce result 0, out_zero 1, out_illegal 1; the entry still flows normally.
REQ-028 in_* SHALL be ignored when in_valid is low or in_ready is low.

Reset
REQ-029 While rst is high at a clock edge: out_valid 0, in_ready 0, skid empty; out_result, out_tag 0, out_zero 1, out_illegal 0.
REQ-030 in_ready SHALL rise the first edge after rst deasserts.
REQ-031 Reset mid-operation SHALL discard both entries without emitting them.

Structure
REQ-032 ALUOpT and its encodings (ADD 0x1 .. PASSB 0xB) SHALL live in the shared processor package, with DATA_WIDTH/ADDR_WIDTH constants; no local redefinition.
REQ-033 Combinational ALU SHALL be one sub-module, alu_core (op, a, b -> result, illegal), instantiated once; the shared skid/main register logic remains in alu_ex_stage.

Verification
REQ-034 ADD a=0xFFFF_FFFF, b=1, out_ready=1 -> next cycle out_result=0, out_zero=1, out_illegal=0.
REQ-035 SRA a=0x8000_0000, b=0x0000_0024 (shamt 4) -> 0xF800_0000; SRL same -> 0x0800_0000; SLT a=0xFFFF_FFFF, b=1 -> 1; SLTU same -> 0.
REQ-036 Back-to-back 3 ops with tags 1,2,3, out_ready low from cycle 1 -> in_ready low after 2 accepts; raising out_ready delivers tags 1,2,3 in order, none lost.
REQ-037 Stream 100 random ops, random in_valid/out_ready toggling -> results match a reference model in order; out_* stable during stalls.
REQ-038 in_op=0x00 and 0x0C -> out_result=0, out_zero=1, out_illegal=1.
REQ-039 Assert rst with both entries full -> next cycle out_valid=0, in_ready=0; one cycle after release in_ready=1, no stale result emitted.
